hamming_enc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered Hamming(11,7) encoder among N_REQ requesters. It accepts 7-bit data words over per-port valid/ready handshakes and drives the selected word to the encoder. It waits out the encoder latency, then presents the 11-bit codeword tagged with the source port on a valid/ready output. Exactly one word is in flight at a time.

---
 rtl/hamming_enc_arbiter.sv | 101 ++++++++++
 tb/tb_hamming_enc_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_arbiter.sv
// hamming_enc_arbiter: round-robin sharing of one registered Hamming(11,7) encoder among N_REQ requesters
module hamming_enc_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int ENC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [7*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [6:0]           enc_data,
  input  logic [10:0]          enc_encoded,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_code,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy
);
  localparam int CNT_W = $clog2(ENC_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, out_id_q, out_id_d, sel, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0] enc_data_q, enc_data_d, word;
  logic [10:0] out_code_q, out_code_d;
  logic out_valid_q, out_valid_d, found, take;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    word = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    for (int i = 0; i < N_REQ; i++)
      word = (sel == ID_W'(i)) ? req_data[7*i +: 7] : word;
  end
  assign take = found && (state_q == IDLE || (state_q == OUT && out_ready));
  assign req_ready = (take && !rst) ? N_REQ'(1) << sel : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    enc_data_d = enc_data_q;
    out_code_d = out_code_q;
    out_id_d = out_id_q;
    out_valid_d = out_valid_q;
    if (state_q == WAIT) begin
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        out_code_d = enc_encoded;
        out_id_d = id_q;
        out_valid_d = 1'b1;
        state_d = OUT;
      end
    end
    if (state_q == OUT && out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
    if (take) begin
      enc_data_d = word;
      ptr_d = sel;
      id_d = sel;
      cnt_d = CNT_W'(ENC_LAT);
      state_d = WAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      cnt_q <= '0;
      enc_data_q <= '0;
      out_code_q <= '0;
      out_id_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      enc_data_q <= enc_data_d;
      out_code_q <= out_code_d;
      out_id_q <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign enc_data = enc_data_q;
  assign out_code = out_code_q;
  assign out_id = out_id_q;
  assign out_valid = out_valid_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb_hamming_enc_arbiter: self-checking bench with table vectors, directed corner sequences and a random scoreboard
module tb_hamming_enc_arbiter;
  localparam int N = 4;
  typedef struct {
    int         port;
    logic [6:0] data;
    logic [1:0] id;
    logic [10:0] code;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_valid2, req_ready2;
  logic [7*N-1:0] req_data, req_data2;
  logic [6:0] enc_data, enc_data2;
  logic [10:0] enc_encoded, enc_encoded2, e2a, out_code, out_code2;
  logic out_valid, out_ready, busy, out_valid2, out_ready2, busy2;
  logic [1:0] out_id, out_id2;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  function automatic logic [10:0] ham(input logic [6:0] d);
    logic [11:1] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    for (int p = 1; p <= 8; p = p * 2)
      for (int q = p + 1; q <= 11; q++)
        if ((q & p) != 0) c[p] = c[p] ^ c[q];
    return c;
  endfunction
  always @(posedge clk) begin
    enc_encoded <= ham(enc_data);
    e2a <= ham(enc_data2);
    enc_encoded2 <= e2a;
  end
  hamming_enc_arbiter #(.N_REQ(4), .ID_W(2), .ENC_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_data(enc_data), .enc_encoded(enc_encoded), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_id(out_id), .busy(busy)
  );
  hamming_enc_arbiter #(.N_REQ(4), .ID_W(2), .ENC_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .enc_data(enc_data2), .enc_encoded(enc_encoded2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_code(out_code2), .out_id(out_id2), .busy(busy2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic run_single(input vec_t v);
    req_data[7*v.port +: 7] = v.data;
    req_valid = 4'b1 << v.port;
    out_ready = 1'b1;
    smp; chk("single_grant", req_ready, 4'b1 << v.port); step;
    req_valid = '0;
    smp; chk("single_ov1", out_valid, 0); chk("single_busy1", busy, 1); step;
    smp; chk("single_ov2", out_valid, 0); step;
    smp; chk("single_ov3", out_valid, 1); chk("single_id", out_id, v.id); chk("single_code", out_code, v.code); step;
    smp; chk("single_idle_busy", busy, 0); chk("single_idle_ov", out_valid, 0); step;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[6];
    logic [6:0] words[N];
    logic [N-1:0] pend;
    logic [6:0] d;
    int m_ptr, m_gcyc, g;
    logic m_inflight, ov_exp, free;
    logic [1:0] m_id;
    logic [10:0] m_code;
    logic [N-1:0] rr_exp;
    tbl[0] = '{2, 7'h05, 2'd2, ham(7'h05)};
    tbl[1] = '{0, 7'h00, 2'd0, 11'h000};
    tbl[2] = '{1, 7'h7f, 2'd1, 11'h7ff};
    tbl[3] = '{3, 7'h2a, 2'd3, ham(7'h2a)};
    tbl[4] = '{1, 7'h01, 2'd1, ham(7'h01)};
    tbl[5] = '{0, 7'h40, 2'd0, ham(7'h40)};
    rst = 1'b1;
    req_valid = '1;
    req_valid2 = '1;
    req_data = 28'($urandom);
    req_data2 = '0;
    out_ready = 1'b1;
    out_ready2 = 1'b1;
    step;
    smp; chk("rst_ready", req_ready, 0); chk("rst_ready2", req_ready2, 0); step;
    smp;
    chk("rst_ov", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_enc", enc_data, 0);
    chk("rst_code", out_code, 0); chk("rst_id", out_id, 0);
    step;
    rst = 1'b0;
    req_valid2 = '0;
    for (int i = 0; i < N; i++) begin
      words[i] = 7'($urandom);
      req_data[7*i +: 7] = words[i];
    end
    req_valid = '1;
    for (int c = 0; c < 18; c++) begin
      smp;
      chk("rr_grant", req_ready, (c % 3 == 0) ? 4'b1 << ((c / 3) % 4) : 4'b0);
      chk("rr_busy", busy, (c == 0) ? 0 : 1);
      if (c >= 3) chk("rr_ov", out_valid, (c % 3 == 0) ? 1 : 0);
      if (c >= 3 && c % 3 == 0) begin
        chk("rr_id", out_id, (c / 3 - 1) % 4);
        chk("rr_code", out_code, ham(words[(c / 3 - 1) % 4]));
      end
      step;
    end
    req_valid = '0;
    smp; chk("rr_last_ov", out_valid, 1); chk("rr_last_id", out_id, 1); chk("rr_last_ready", req_ready, 0); step;
    smp; chk("rr_drain_busy", busy, 0); step;
    foreach (tbl[i]) run_single(tbl[i]);
    req_data[13:7] = 7'h33;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    smp; chk("stall_grant", req_ready, 4'b0010); step;
    req_valid = 4'b0100;
    req_data[20:14] = 7'h4c;
    smp; step;
    smp; chk("stall_ov2", out_valid, 0); step;
    for (int k = 0; k < 5; k++) begin
      smp;
      chk("stall_ov", out_valid, 1); chk("stall_id", out_id, 1); chk("stall_code", out_code, ham(7'h33));
      chk("stall_ready", req_ready, 0); chk("stall_busy", busy, 1);
      step;
    end
    out_ready = 1'b1;
    smp; chk("stall_hs_grant", req_ready, 4'b0100); chk("stall_hs_ov", out_valid, 1); step;
    req_valid = '0;
    smp; chk("stall_next_ov", out_valid, 0); chk("stall_next_busy", busy, 1); step;
    step;
    smp; chk("stall_next_out", out_valid, 1); chk("stall_next_id", out_id, 2); chk("stall_next_code", out_code, ham(7'h4c)); step;
    smp; chk("stall_idle", busy, 0); step;
    req_data[27:21] = 7'h6b;
    req_valid = 4'b1000;
    smp; chk("rstw_grant", req_ready, 4'b1000); step;
    req_valid = '0;
    rst = 1'b1;
    smp; chk("rstw_ready", req_ready, 0); step;
    rst = 1'b0;
    req_valid = 4'b1010;
    req_data[13:7] = 7'h11;
    smp;
    chk("rstw_ov", out_valid, 0); chk("rstw_busy", busy, 0); chk("rstw_enc", enc_data, 0);
    chk("rstw_code", out_code, 0); chk("rstw_id", out_id, 0); chk("rstw_grant1", req_ready, 4'b0010);
    step;
    req_valid = 4'b1000;
    smp; chk("rstw_ov3", out_valid, 0); step;
    smp; chk("rstw_ov4", out_valid, 0); step;
    smp; chk("rstw_out", out_valid, 1); chk("rstw_out_id", out_id, 1); chk("rstw_out_code", out_code, ham(7'h11));
    chk("rstw_grant3", req_ready, 4'b1000); step;
    req_valid = '0;
    step;
    step;
    smp; chk("rstw_out2", out_valid, 1); chk("rstw_out2_id", out_id, 3); chk("rstw_out2_code", out_code, ham(7'h6b)); step;
    smp; chk("rstw_idle", busy, 0); step;
    for (int n = 0; n < 3; n++) begin
      d = 7'($urandom);
      req_data2[6:0] = d;
      req_valid2 = 4'b0001;
      smp; chk("lat2_grant", req_ready2, 4'b0001); step;
      req_valid2 = '0;
      for (int c = 1; c <= 3; c++) begin
        smp; chk("lat2_ov_low", out_valid2, 0); step;
      end
      smp; chk("lat2_ov", out_valid2, 1); chk("lat2_id", out_id2, 0); chk("lat2_code", out_code2, ham(d)); step;
      smp; chk("lat2_idle", busy2, 0); step;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    m_ptr = N - 1;
    m_inflight = 1'b0;
    m_gcyc = 0;
    m_id = '0;
    m_code = '0;
    pend = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          words[i] = 7'($urandom);
        end
      for (int i = 0; i < N; i++) req_data[7*i +: 7] = words[i];
      req_valid = pend;
      out_ready = $urandom_range(0, 2) != 0;
      smp;
      ov_exp = m_inflight && cyc >= m_gcyc + 3;
      free = !m_inflight || (ov_exp && out_ready);
      g = -1;
      if (free)
        for (int k = 1; k <= N; k++)
          if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      rr_exp = (g >= 0) ? 4'b1 << g : 4'b0;
      chk("rand_ready", req_ready, rr_exp);
      chk("rand_ov", out_valid, ov_exp);
      chk("rand_busy", busy, m_inflight);
      if (ov_exp) begin
        chk("rand_id", out_id, m_id);
        chk("rand_code", out_code, m_code);
      end
      if (ov_exp && out_ready) m_inflight = 1'b0;
      if (g >= 0) begin
        m_inflight = 1'b1;
        m_gcyc = cyc;
        m_id = 2'(g);
        m_code = ham(words[g]);
        m_ptr = g;
        pend[g] = 1'b0;
      end
      step;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
